// File: rtl/note_pkg.sv
// Shared note payload and sequencer state types for the note-entry datapath.
package note_pkg;

  typedef struct packed {
    logic       tom;
    logic [2:0] nota;
  } note_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/note_buffer.sv
// DEPTH-entry note register file: one synchronous write port, one combinational read port.
module note_buffer
  import note_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  note_t         wdata,
  input  logic [AW-1:0] raddr,
  output note_t         rdata
);

  note_t mem [DEPTH];

  // Contents are never reset; entries at or above count are unreachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/note_sequencer.sv
// Record-and-playback note controller: captures notes on ok, replays them on play
// with a fixed on-time per note and a blank gap between notes.
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TICKS_PER_NOTE = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_500_000,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ok,
  input  logic          tom,
  input  logic [2:0]    nota,
  input  logic          play,
  input  logic          clear,
  output logic          out_tom,
  output logic [2:0]    out_nota,
  output logic          out_valid,
  output logic          fim,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMAX      = (TICKS_PER_NOTE > GAP_TICKS) ? TICKS_PER_NOTE : GAP_TICKS;
  localparam int unsigned TW        = $clog2(TMAX + 1);
  localparam int unsigned NOTE_LAST = TICKS_PER_NOTE - 1;
  localparam int unsigned GAP_LAST  = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

  seq_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] count_q, count_d;
  logic          ok_q, play_q;
  note_t         note_q, note_d;
  logic          valid_q, valid_d;
  logic          fim_q, fim_d;
  logic          full_q;

  logic          ok_rise, play_rise, last_note;
  logic          we;
  note_t         wdata, rdata;

  assign ok_rise   = ok & ~ok_q;
  assign play_rise = play & ~play_q;
  assign last_note = (CW'(idx_q) == (count_q - CW'(1)));
  assign wdata     = '{tom: tom, nota: nota};

  note_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (AW'(count_q)),
    .wdata (wdata),
    .raddr (idx_d),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tick_q  <= '0;
      count_q <= '0;
      ok_q    <= 1'b0;
      play_q  <= 1'b0;
      note_q  <= '0;
      valid_q <= 1'b0;
      fim_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      ok_q    <= ok;
      play_q  <= play;
      note_q  <= note_d;
      valid_q <= valid_d;
      fim_q   <= fim_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  // Next state; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    count_d = count_q;
    we      = 1'b0;

    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      tick_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play_rise) begin
            idx_d   = '0;
            tick_d  = '0;
            state_d = (count_q == '0) ? DONE : PLAY;
          end else if (ok_rise && !full_q) begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        PLAY: begin
          if (tick_q == TW'(NOTE_LAST)) begin
            tick_d = '0;
            if (last_note) begin
              state_d = DONE;
            end else if (GAP_TICKS == 0) begin
              idx_d = idx_q + AW'(1);
            end else begin
              state_d = GAP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        GAP: begin
          if (tick_q == TW'(GAP_LAST)) begin
            tick_d  = '0;
            idx_d   = idx_q + AW'(1);
            state_d = PLAY;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d == PLAY);
    fim_d   = (state_d == DONE);
    note_d  = valid_d ? rdata : note_q;
  end

  assign out_tom   = note_q.tom;
  assign out_nota  = note_q.nota;
  assign out_valid = valid_q;
  assign fim       = fim_q;
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with DEPTH=4, TICKS_PER_NOTE=3, GAP_TICKS=1.
module tb_note_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TPN   = 3;
  localparam int unsigned GAP   = 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          ok, tom, play, clear;
  logic [2:0]    nota;
  logic          out_tom, out_valid, fim, full;
  logic [2:0]    out_nota;
  logic [CW-1:0] count;

  int tests  = 0;
  int failed = 0;

  note_sequencer #(.DEPTH(DEPTH), .TICKS_PER_NOTE(TPN), .GAP_TICKS(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .ok        (ok),
    .tom       (tom),
    .nota      (nota),
    .play      (play),
    .clear     (clear),
    .out_tom   (out_tom),
    .out_nota  (out_nota),
    .out_valid (out_valid),
    .fim       (fim),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input logic t, input logic [2:0] n);
    tom  = t;
    nota = n;
    ok   = 1'b1;
    step();
    ok   = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    tests++;
    if ({out_tom, out_nota, out_valid, fim, count, full} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got tom=%b nota=%0d valid=%b fim=%b count=%0d full=%b, want all 0",
               out_tom, out_nota, out_valid, fim, count, full);
    end
  endtask

  task automatic test_playback();
    logic [3:0] notes [3];
    logic       exp_v, exp_f;
    int         k, pos;
    notes[0] = 4'h2; notes[1] = 4'hC; notes[2] = 4'h6;
    do_clear();
    record(1'b0, 3'd2);
    record(1'b1, 3'd4);
    record(1'b0, 3'd6);
    tests++;
    if (count !== CW'(3)) begin
      failed++;
      $display("FAIL play_count: got %0d want 3", count);
    end
    play = 1'b1;
    step();
    play = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      k     = (c - 1) / 4;
      pos   = (c - 1) % 4;
      exp_v = (c <= 12) && (pos < 3);
      exp_f = (c == 12);
      tests++;
      if (out_valid !== exp_v || fim !== exp_f) begin
        failed++;
        $display("FAIL play_timing t+%0d: got valid=%b fim=%b want valid=%b fim=%b",
                 c, out_valid, fim, exp_v, exp_f);
      end
      if (exp_v) begin
        tests++;
        if ({out_tom, out_nota} !== notes[k]) begin
          failed++;
          $display("FAIL play_note t+%0d: got %h want %h", c, {out_tom, out_nota}, notes[k]);
        end
      end
      if (c == 4 || c == 8) begin
        tests++;
        if ({out_tom, out_nota} !== notes[k]) begin
          failed++;
          $display("FAIL gap_hold t+%0d: got %h want %h", c, {out_tom, out_nota}, notes[k]);
        end
      end
      step();
    end
    tests++;
    if (count !== CW'(3)) begin
      failed++;
      $display("FAIL replay_count: got %0d want 3", count);
    end
  endtask

  task automatic test_full();
    logic [3:0] notes [5];
    logic       exp_v, exp_f;
    int         k, pos;
    notes[0] = 4'h1; notes[1] = 4'hA; notes[2] = 4'h3; notes[3] = 4'hD; notes[4] = 4'hF;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      record(notes[i][3], notes[i][2:0]);
      if (i == 2) begin
        tests++;
        if (full !== 1'b0 || count !== CW'(3)) begin
          failed++;
          $display("FAIL full_early: got count=%0d full=%b want 3/0", count, full);
        end
      end
    end
    tests++;
    if (count !== CW'(4) || full !== 1'b1) begin
      failed++;
      $display("FAIL full_flag: got count=%0d full=%b want 4/1", count, full);
    end
    play = 1'b1;
    step();
    play = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      k     = (c - 1) / 4;
      pos   = (c - 1) % 4;
      exp_v = (c <= 16) && (pos < 3);
      exp_f = (c == 16);
      tests++;
      if (out_valid !== exp_v || fim !== exp_f ||
          (exp_v && {out_tom, out_nota} !== notes[k])) begin
        failed++;
        $display("FAIL full_play t+%0d: got valid=%b fim=%b note=%h want valid=%b fim=%b note=%h",
                 c, out_valid, fim, {out_tom, out_nota}, exp_v, exp_f, notes[k]);
      end
      step();
    end
  endtask

  task automatic test_held_ok();
    do_clear();
    tom  = 1'b1;
    nota = 3'd5;
    ok   = 1'b1;
    for (int i = 0; i < 10; i++) step();
    ok = 1'b0;
    step();
    tests++;
    if (count !== CW'(1)) begin
      failed++;
      $display("FAIL held_ok: got count=%0d want 1", count);
    end
    play = 1'b1;
    step();
    play = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || {out_tom, out_nota} !== 4'hD) begin
      failed++;
      $display("FAIL held_note: got valid=%b note=%h want 1/d", out_valid, {out_tom, out_nota});
    end
    ok = 1'b1;
    step();
    ok = 1'b0;
    step();
    step();
    tests++;
    if (fim !== 1'b1) begin
      failed++;
      $display("FAIL single_fim: got fim=%b want 1 at t+4", fim);
    end
    step();
    tests++;
    if (count !== CW'(1)) begin
      failed++;
      $display("FAIL ok_in_play: got count=%0d want 1", count);
    end
  endtask

  task automatic test_clear_mid();
    int fim_seen;
    do_clear();
    record(1'b0, 3'd1);
    record(1'b0, 3'd2);
    record(1'b0, 3'd3);
    play = 1'b1;
    step();
    play = 1'b0;
    for (int i = 0; i < 4; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || count !== CW'(0) || fim !== 1'b0) begin
      failed++;
      $display("FAIL clear_mid: got valid=%b count=%0d fim=%b want 0/0/0", out_valid, count, fim);
    end
    fim_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (fim === 1'b1) fim_seen++;
      step();
    end
    tests++;
    if (fim_seen != 0) begin
      failed++;
      $display("FAIL clear_no_fim: got %0d fim pulses want 0", fim_seen);
    end
    play = 1'b1;
    step();
    play = 1'b0;
    tests++;
    if (fim !== 1'b1 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL clear_then_play: got fim=%b valid=%b want 1/0", fim, out_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_v, exp_f;
    int   pos;
    do_clear();
    record(1'b1, 3'd0);
    record(1'b0, 3'd7);
    tom  = 1'b1;
    nota = 3'd3;
    ok   = 1'b1;
    play = 1'b1;
    step();
    ok   = 1'b0;
    play = 1'b0;
    tests++;
    if (count !== CW'(2)) begin
      failed++;
      $display("FAIL play_ok_count: got %0d want 2", count);
    end
    for (int c = 1; c <= 9; c++) begin
      pos   = (c - 1) % 4;
      exp_v = (c <= 8) && (pos < 3);
      exp_f = (c == 8);
      tests++;
      if (out_valid !== exp_v || fim !== exp_f) begin
        failed++;
        $display("FAIL play_ok_timing t+%0d: got valid=%b fim=%b want valid=%b fim=%b",
                 c, out_valid, fim, exp_v, exp_f);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    record(1'b1, 3'd6);
    record(1'b0, 3'd4);
    play = 1'b1;
    step();
    play = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({out_tom, out_nota, out_valid, fim, count, full} !== '0) begin
      failed++;
      $display("FAIL reset_mid: got tom=%b nota=%0d valid=%b fim=%b count=%0d full=%b want all 0",
               out_tom, out_nota, out_valid, fim, count, full);
    end
    step();
    reset = 1'b0;
    step();
    play = 1'b1;
    step();
    play = 1'b0;
    tests++;
    if (fim !== 1'b1 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_then_play: got fim=%b valid=%b want 1/0", fim, out_valid);
    end
    step();
    tests++;
    if (fim !== 1'b0) begin
      failed++;
      $display("FAIL fim_one_cycle: got fim=%b want 0", fim);
    end
  endtask

  initial begin
    reset = 1'b1;
    ok    = 1'b0;
    tom   = 1'b0;
    nota  = 3'd0;
    play  = 1'b0;
    clear = 1'b0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_playback();
    test_full();
    test_held_ok();
    test_clear_mid();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Record-and-playback controller for the note-entry datapath. Captures notes (`tom`, `nota`) into a small buffer on each `ok` press, then replays them on `play`. Each note is held for a fixed tick count, with a blank gap between notes. Outputs drive the existing `display7seg` decoder directly; `fim` flags end of playback.

## Interface
Parameters:
- `DEPTH`, 8: note buffer capacity (≥1).
- `TICKS_PER_NOTE`, 25_000_000: cycles each note is shown (≥1; 0.5 s at 50 MHz).
- `GAP_TICKS`, 2_500_000: blank cycles between consecutive notes (0 = no gap state).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears state, counters and outputs.
- `ok` in 1: record strobe, level input; acted on at its rising edge.
- `tom` in 1: sharp flag of the note to record.
- `nota` in 3: note code to record.
- `play` in 1: playback strobe, level input; acted on at its rising edge.
- `clear` in 1: level; empties the buffer and aborts playback.
- `out_tom` out 1: sharp flag of the note being played (to `display7seg`).
- `out_nota` out 3: note being played (to `display7seg`).
- `out_valid` out 1: 1 while a note is shown; display blanks when 0.
- `fim` out 1: one-cycle pulse when playback completes.
- `count` out $clog2(DEPTH+1): notes stored.
- `full` out 1: `count == DEPTH`.

## Operation
- Inputs are synchronous to `clk`; debouncing is upstream.
- Edge detect: registered copies of `ok` and `play`. Rise = current 1 and previous 0. `tom`/`nota` are sampled in the rise cycle.
- States: IDLE, PLAY, GAP, DONE.
- IDLE:
  - `ok` rise with `!full`: write {tom, nota} at index `count`, then `count+1`. With `full`, the rise is ignored.
  - `play` rise with `count>0`: go to PLAY with index 0 and tick counter 0.
  - `play` rise with `count==0`: go straight to DONE.
  - `play` and `ok` rising in the same cycle: `play` wins; the note is not recorded.
- PLAY:
  - Outputs show entry[idx] with `out_valid=1`.
  - After `TICKS_PER_NOTE` cycles: if idx is the last note, go to DONE. Otherwise go to GAP, or if `GAP_TICKS==0` go directly to PLAY with idx+1.
- GAP: `out_valid=0`. After `GAP_TICKS` cycles, go to PLAY with idx+1 and tick counter 0.
- DONE: `fim=1` for exactly one cycle, `out_valid=0`; next state IDLE. Buffer and `count` are kept, so replay is possible.
- `ok` rises outside IDLE are ignored; `play` rises outside IDLE are ignored, so there is no restart mid-play.
- `clear` (any state, highest priority, synchronous):
  - next state IDLE, `count=0`, `out_valid=0`, no `fim`.
  - With a simultaneous `ok` or `play`, `clear` wins.
- `reset` mid-operation: immediate IDLE; `count=0`; all outputs 0. Buffer contents need not be reset (unreachable while `count=0`).
- `out_tom`/`out_nota` hold the last played value when `out_valid=0`, and are 0 after reset.
- Tick counter width: $clog2(max(TICKS_PER_NOTE, GAP_TICKS)+1). It compares against parameter−1 and never wraps.

## Timing
- Reset values: `out_tom=0`, `out_nota=0`, `out_valid=0`, `fim=0`, `count=0`, `full=0`; state IDLE.
- Record: `ok` rise in cycle t gives `count` updated at t+1; `full` follows `count` in the same cycle.
- Play start: `play` rise in cycle t gives `out_valid=1` with entry 0 at t+1.
- Note k (0-based) is valid from t+1+k·(TICKS_PER_NOTE+GAP_TICKS) for TICKS_PER_NOTE cycles.
- `fim` occurs at t+1+N·TICKS_PER_NOTE+(N−1)·GAP_TICKS for N notes. IDLE is reached the cycle after `fim`.
- Empty-buffer play: `fim` at t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `note_pkg`:
  - `note_t` packed struct {tom, nota[2:0]}.
  - `seq_state_t` enum {IDLE, PLAY, GAP, DONE}.
  - Reused by the entry FSM and display path.
- Sub-module `note_buffer`: DEPTH×`note_t` register file with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- The FSM, counters and edge detectors live in `note_sequencer`.

## Test plan
Bench parameters: DEPTH=4, TICKS_PER_NOTE=3, GAP_TICKS=1.
- Reset asserted mid-PLAY → all outputs 0 immediately, `count=0`; a following `play` rise gives `fim` at t+1.
- Record (tom,nota)=(0,2),(1,4),(0,6) then `play` rise at t → `out_valid` at t+1..t+3 (0,2), t+5..t+7 (1,4), t+9..t+11 (0,6); blanks at t+4 and t+8; `fim` at t+12; IDLE at t+13.
- 5 `ok` rises with distinct notes → `count=4`, `full=1`; 5th note absent on playback.
- Held `ok` for 10 cycles → exactly one note recorded. `ok` pressed during PLAY → `count` unchanged.
- `clear` at t+5 of a playback → IDLE at t+6, `count=0`, `out_valid=0`, no `fim` pulse.
- `play` and `ok` rising in the same cycle with `count=2` → playback of 2 notes; `count` stays 2.
